// File: rtl/cache_2way_if.sv
// Processor-side and memory-side bus of the 2-way cache.
// The cache takes the slave modport and the requester/memory model takes the master modport.
interface cache_2way_if;
    logic         proc_read;
    logic         proc_write;
    logic [29:0]  proc_addr;
    logic [31:0]  proc_wdata;
    logic [31:0]  proc_rdata;
    logic         proc_stall;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;

    modport slave (
        input  proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
        output proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
        input  proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/cache_2way.sv
// 2-way set-associative, write-back / write-allocate cache with 4-word lines.
// A miss selects a victim, writes it back if dirty, then refills it from memory.
module cache_2way #(
    parameter int SET_BITS = 2,
    parameter int TAG_W    = 28 - SET_BITS
) (
    input  logic        clk,
    input  logic        proc_reset_n,
    cache_2way_if.slave bus
);
    localparam int          NUM_SETS = 1 << SET_BITS;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, CMPTAG, WRTMEM, RDMEM} state_t;

    state_t                state;
    logic [127:0]          data_q  [NUM_SETS][2];
    logic [TAG_W-1:0]      tag_q   [NUM_SETS][2];
    logic [1:0]            valid_q [NUM_SETS];
    logic [1:0]            dirty_q [NUM_SETS];
    logic [NUM_SETS-1:0]   lru_q;
    logic                  victim_q;

    logic [SET_BITS-1:0]   set_idx;
    logic [TAG_W-1:0]      req_tag;
    logic [6:0]            word_lsb;
    logic                  req_valid;
    logic                  hit0;
    logic                  hit1;
    logic                  hit;
    logic                  hit_way;
    logic                  victim_way;

    assign set_idx  = bus.proc_addr[SET_BITS+1:2];
    assign req_tag  = bus.proc_addr[29:SET_BITS+2];
    assign word_lsb = {bus.proc_addr[1:0], 5'd0};

    always_comb begin
        req_valid = bus.proc_read ^ bus.proc_write;
        hit0      = valid_q[set_idx][0] && (tag_q[set_idx][0] == req_tag);
        hit1      = valid_q[set_idx][1] && (tag_q[set_idx][1] == req_tag);
        hit       = hit0 || hit1;
        hit_way   = !hit0;
        // Fill empty ways in order before evicting anything.
        if (!valid_q[set_idx][0])
            victim_way = 1'b0;
        else if (!valid_q[set_idx][1])
            victim_way = 1'b1;
        else
            victim_way = lru_q[set_idx];
    end

    // NOTE: every output gets its default before the case, so no path through
    // this block leaves a signal unassigned and no latch is inferred.
    always_comb begin
        bus.proc_stall = 1'b1;
        bus.proc_rdata = NOP;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.mem_addr   = bus.proc_addr[29:2];
        bus.mem_wdata  = '0;
        unique case (state)
            CMPTAG: begin
                bus.proc_stall = req_valid && !hit;
                if (req_valid && bus.proc_read && hit)
                    bus.proc_rdata = data_q[set_idx][hit_way][word_lsb +: 32];
            end
            WRTMEM: begin
                bus.mem_write = 1'b1;
                bus.mem_wdata = data_q[set_idx][victim_q];
                bus.mem_addr  = {tag_q[set_idx][victim_q], set_idx};
            end
            RDMEM: bus.mem_read = 1'b1;
            default: ;
        endcase
    end

    // NOTE: line storage is built from flops, so it is cleared along with the
    // control state; a reset mid-transfer therefore leaves no partial line.
    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) begin
            state    <= IDLE;
            victim_q <= 1'b0;
            lru_q    <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                for (int w = 0; w < 2; w++) begin
                    data_q[s][w] <= '0;
                    tag_q[s][w]  <= '0;
                end
            end
        end else begin
            unique case (state)
                IDLE: state <= CMPTAG;
                CMPTAG: begin
                    if (req_valid && hit) begin
                        lru_q[set_idx] <= ~hit_way;
                        if (bus.proc_write) begin
                            data_q[set_idx][hit_way][word_lsb +: 32] <= bus.proc_wdata;
                            dirty_q[set_idx][hit_way]                <= 1'b1;
                        end
                    end else if (req_valid) begin
                        victim_q <= victim_way;
                        state    <= (valid_q[set_idx][victim_way] && dirty_q[set_idx][victim_way])
                                    ? WRTMEM : RDMEM;
                    end
                end
                WRTMEM: begin
                    if (bus.mem_ready) begin
                        dirty_q[set_idx][victim_q] <= 1'b0;
                        state                      <= RDMEM;
                    end
                end
                RDMEM: begin
                    if (bus.mem_ready) begin
                        data_q[set_idx][victim_q]  <= bus.mem_rdata;
                        tag_q[set_idx][victim_q]   <= req_tag;
                        valid_q[set_idx][victim_q] <= 1'b1;
                        dirty_q[set_idx][victim_q] <= 1'b0;
                        state                      <= CMPTAG;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_2way.sv
// Directed bench for cache_2way: cold fills, write hits, LRU eviction,
// dirty write-back, no-op requests and asynchronous reset mid-refill.
module tb_cache_2way;
    logic clk;
    logic proc_reset_n;
    int   checks;
    int   errors;

    cache_2way_if bus();

    cache_2way dut (
        .clk          (clk),
        .proc_reset_n (proc_reset_n),
        .bus          (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [127:0] FILL_A  = {32'hAAAA0003, 32'hAAAA0002, 32'hAAAA0001, 32'hAAAA0000};
    localparam logic [127:0] FILL_C  = {32'hCCCC0003, 32'hCCCC0002, 32'hCCCC0001, 32'hCCCC0000};
    localparam logic [127:0] FILL_D  = {32'hDDDD0003, 32'hDDDD0002, 32'hDDDD0001, 32'hDDDD0000};
    localparam logic [127:0] FILL_E  = {32'hEEEE0003, 32'hEEEE0002, 32'hEEEE0001, 32'hEEEE0000};
    localparam logic [127:0] FILL_S1 = {32'h55550003, 32'h55550002, 32'h55550001, 32'h55550000};

    // Observations from the latest request.
    logic [31:0]  got_rdata;
    logic         rd_seen;
    logic         wb_seen;
    logic         both_seen;
    logic [27:0]  rd_addr;
    logic [27:0]  wb_addr;
    logic [127:0] wb_data;
    int           stall_cycles;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Presents one request and plays memory with a 3-cycle response.
    task automatic do_req(input logic rd, input logic wr, input logic [29:0] addr,
                          input logic [31:0] wd, input logic [127:0] fill);
        int cnt;
        bit done;
        @(posedge clk);
        #1;
        bus.proc_read  = rd;
        bus.proc_write = wr;
        bus.proc_addr  = addr;
        bus.proc_wdata = wd;
        rd_seen      = 1'b0;
        wb_seen      = 1'b0;
        both_seen    = 1'b0;
        rd_addr      = '0;
        wb_addr      = '0;
        wb_data      = '0;
        got_rdata    = '0;
        stall_cycles = 0;
        cnt          = 0;
        done         = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            bus.mem_ready = 1'b0;
            if (bus.mem_read && bus.mem_write) both_seen = 1'b1;
            if (!bus.proc_stall) begin
                done      = 1'b1;
                got_rdata = bus.proc_rdata;
            end else begin
                stall_cycles++;
                if (bus.mem_write) begin
                    wb_seen = 1'b1;
                    wb_addr = bus.mem_addr;
                    wb_data = bus.mem_wdata;
                end
                if (bus.mem_read) begin
                    rd_seen = 1'b1;
                    rd_addr = bus.mem_addr;
                end
                if (bus.mem_read || bus.mem_write) begin
                    cnt++;
                    if (cnt == 3) begin
                        bus.mem_ready = 1'b1;
                        bus.mem_rdata = fill;
                        cnt = 0;
                    end
                end
            end
        end
        if (!done) check("req_timeout", 128'(0), 128'(1));
        check("mem_rd_wr_exclusive", 128'(both_seen), 128'(0));
    endtask

    initial begin
        logic got_rd;
        checks = 0;
        errors = 0;
        proc_reset_n   = 1'b0;
        bus.proc_read  = 1'b0;
        bus.proc_write = 1'b0;
        bus.proc_addr  = '0;
        bus.proc_wdata = '0;
        bus.mem_rdata  = '0;
        bus.mem_ready  = 1'b0;

        #2;
        check("rst_stall",     128'(bus.proc_stall), 128'(1));
        check("rst_mem_read",  128'(bus.mem_read),   128'(0));
        check("rst_mem_write", 128'(bus.mem_write),  128'(0));
        repeat (2) @(negedge clk);
        proc_reset_n = 1'b1;
        #1;
        check("idle_stall", 128'(bus.proc_stall), 128'(1));
        @(posedge clk);
        #1;
        check("cmptag_noreq_stall", 128'(bus.proc_stall), 128'(0));

        // Cold read of 0x10: refill from block 0x4.
        do_req(1'b1, 1'b0, 30'h10, 32'h0, FILL_A);
        check("cold_rd_mem_read", 128'(rd_seen),   128'(1));
        check("cold_rd_mem_addr", 128'(rd_addr),   128'(28'h4));
        check("cold_rd_no_wb",    128'(wb_seen),   128'(0));
        check("cold_rd_data",     128'(got_rdata), 128'(32'hAAAA0000));

        // Write hit, then read it back, plus a neighbouring word.
        do_req(1'b0, 1'b1, 30'h10, 32'h12345678, '0);
        check("wr_hit_no_stall", 128'(stall_cycles), 128'(0));
        do_req(1'b1, 1'b0, 30'h10, 32'h0, '0);
        check("rd_after_wr_data", 128'(got_rdata), 128'(32'h12345678));
        check("rd_after_wr_nomem", 128'(rd_seen), 128'(0));
        do_req(1'b1, 1'b0, 30'h11, 32'h0, '0);
        check("rd_word1", 128'(got_rdata), 128'(32'hAAAA0001));

        // Second way of set 0 fills without eviction.
        do_req(1'b1, 1'b0, 30'h90, 32'h0, FILL_C);
        check("fill_way1_no_wb",   128'(wb_seen),   128'(0));
        check("fill_way1_addr",    128'(rd_addr),   128'(28'h24));
        check("fill_way1_data",    128'(got_rdata), 128'(32'hCCCC0000));

        // Set full, LRU points at the dirty 0x10 line: write-back then refill.
        do_req(1'b1, 1'b0, 30'h50, 32'h0, FILL_D);
        check("dirty_wb_seen",  128'(wb_seen), 128'(1));
        check("dirty_wb_addr",  128'(wb_addr), 128'(28'h4));
        check("dirty_wb_data",  wb_data,
              {32'hAAAA0003, 32'hAAAA0002, 32'hAAAA0001, 32'h12345678});
        check("dirty_rd_addr",  128'(rd_addr), 128'(28'h14));
        check("dirty_rd_data",  128'(got_rdata), 128'(32'hDDDD0000));

        // Touch 0x90 so 0x50 becomes LRU; miss on 0xD0 evicts the clean 0x50.
        do_req(1'b1, 1'b0, 30'h90, 32'h0, '0);
        check("lru_touch_nomem", 128'(rd_seen), 128'(0));
        do_req(1'b1, 1'b0, 30'hD0, 32'h0, FILL_E);
        check("evict_clean_no_wb", 128'(wb_seen), 128'(0));
        check("evict_rd_addr",     128'(rd_addr), 128'(28'h34));
        do_req(1'b1, 1'b0, 30'h90, 32'h0, '0);
        check("survivor_hit_nomem", 128'(rd_seen),   128'(0));
        check("survivor_hit_data",  128'(got_rdata), 128'(32'hCCCC0000));
        do_req(1'b1, 1'b0, 30'h50, 32'h0, FILL_D);
        check("evicted_line_misses", 128'(rd_seen), 128'(1));

        // A different set leaves set 0 untouched.
        do_req(1'b1, 1'b0, 30'h14, 32'h0, FILL_S1);
        check("set1_rd_addr", 128'(rd_addr),   128'(28'h5));
        check("set1_rd_data", 128'(got_rdata), 128'(32'h55550000));
        do_req(1'b1, 1'b0, 30'h90, 32'h0, '0);
        check("set0_unaffected", 128'(rd_seen), 128'(0));

        // Read and write together is a no-op.
        @(posedge clk);
        #1;
        bus.proc_read  = 1'b1;
        bus.proc_write = 1'b1;
        bus.proc_addr  = 30'h90;
        bus.proc_wdata = 32'hDEADBEEF;
        @(negedge clk);
        check("noop_stall",     128'(bus.proc_stall), 128'(0));
        check("noop_mem_read",  128'(bus.mem_read),   128'(0));
        check("noop_mem_write", 128'(bus.mem_write),  128'(0));
        check("noop_rdata",     128'(bus.proc_rdata), 128'(32'h00000013));
        do_req(1'b1, 1'b0, 30'h90, 32'h0, '0);
        check("noop_no_change", 128'(got_rdata), 128'(32'hCCCC0000));
        check("noop_no_mem",    128'(rd_seen),   128'(0));

        // Asynchronous reset in the middle of a refill.
        @(posedge clk);
        #1;
        bus.proc_read  = 1'b1;
        bus.proc_write = 1'b0;
        bus.proc_addr  = 30'h24;
        got_rd = 1'b0;
        for (int i = 0; i < 10 && !got_rd; i++) begin
            @(negedge clk);
            got_rd = bus.mem_read;
        end
        check("rst_mid_reached_rdmem", 128'(got_rd), 128'(1));
        #1;
        proc_reset_n = 1'b0;
        #1;
        check("rst_mid_mem_read", 128'(bus.mem_read),   128'(0));
        check("rst_mid_stall",    128'(bus.proc_stall), 128'(1));
        bus.proc_read = 1'b0;
        repeat (2) @(negedge clk);
        proc_reset_n = 1'b1;
        do_req(1'b1, 1'b0, 30'h90, 32'h0, FILL_C);
        check("post_rst_misses", 128'(rd_seen),   128'(1));
        check("post_rst_data",   128'(got_rdata), 128'(32'hCCCC0000));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cache_2way.md
CACHE_2WAY -- requirements
Module: cache_2way

Interface
REQ-001 The block SHALL have parameter SET_BITS, default 2, giving the log2 of the set count (2 gives 4 sets).
REQ-002 The block SHALL have parameter TAG_W, default 28-SET_BITS, giving the tag width in bits.
REQ-003 The block SHALL have these ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- proc_reset_n  input  1  reset, asynchronous, active-low.
- proc_read  input  1  processor read request.
- proc_write  input  1  processor write request.
- proc_addr  input  30  processor word address: [29:SET_BITS+2] tag, [SET_BITS+1:2] set, [1:0] word.
- proc_wdata  input  32  processor write data.
- proc_rdata  output  32  processor read data.
- proc_stall  output  1  processor must hold its request.
- mem_read  output  1  memory block read request.
- mem_write  output  1  memory block write request.
- mem_addr  output  28  memory block address.
- mem_wdata  output  128  memory write block; word n is bits [32n+31:32n].
- mem_rdata  input  128  memory read block.
- mem_ready  input  1  memory has completed the current request.

Function
REQ-004 Organisation SHALL be 2-way set-associative, 2^SET_BITS sets, 4 words per line, write-back with write-allocate.
REQ-005 Each line SHALL hold: valid, dirty, TAG_W tag, 128 data bits. Each set SHALL hold one lru bit naming the way to evict next.
REQ-006 Valid request SHALL mean proc_read XOR proc_write; both high or both low is a no-op (no stall, no state change).
REQ-007 FSM states SHALL be IDLE, CMPTAG, WRTMEM, RDMEM.
REQ-008 IDLE: proc_stall=1; next state CMPTAG unconditionally.
REQ-009 CMPTAG hit (a valid way whose tag matches): proc_stall=0, zero extra cycles; lru[set] <= other way.
- read hit: proc_rdata = the addressed word of the hit way, combinationally.
- write hit: the addressed word <= proc_wdata and dirty <= 1 at the clock edge.
REQ-010 CMPTAG miss on a valid request: proc_stall=1; the victim way SHALL be selected and registered that cycle.
- victim rule: the first invalid way (way0 before way1); if both ways are valid, way lru[set].
- next state WRTMEM if the victim is valid and dirty, else RDMEM.
REQ-011 WRTMEM SHALL drive the following until mem_ready=1, then go to RDMEM:
- mem_write=1, proc_stall=1.
- mem_wdata = victim data.
- mem_addr = {victim tag, set}.
At the mem_ready edge the victim dirty bit SHALL be cleared.
REQ-012 RDMEM SHALL drive mem_read=1, proc_stall=1 and mem_addr=proc_addr[29:2] until mem_ready=1.
- at that edge the victim SHALL load data <= mem_rdata, tag <= proc_addr tag, valid <= 1, dirty <= 0.
- next state CMPTAG, where the request then hits.
REQ-013 mem_read and mem_write SHALL never be high together, and neither SHALL be high outside RDMEM/WRTMEM.
REQ-014 Defaults outside the states that drive them SHALL be:
- proc_rdata = 32'h00000013 (NOP) when not a read hit.
- mem_wdata = 0 outside WRTMEM.
- mem_addr = proc_addr[29:2] outside WRTMEM.
REQ-015 Processor inputs SHALL be held stable by the requester while proc_stall=1; the registered victim SHALL NOT change during WRTMEM/RDMEM.
REQ-016 Lines in other sets and the non-victim way SHALL be unaffected by any miss sequence.

Reset
REQ-017 While proc_reset_n=0, regardless of clk, the block SHALL hold:
- state = IDLE.
- all valid, dirty and lru bits = 0; data and tags = 0.
- mem_read = 0, mem_write = 0, proc_stall = 1.
REQ-018 Reset asserted mid-WRTMEM/RDMEM SHALL abort the transfer immediately, with no partial line update.
REQ-019 The first edge after proc_reset_n rises SHALL move the FSM from IDLE to CMPTAG.

Verification
REQ-020 Cold read of proc_addr=0x10, mem_ready after 3 cycles with mem_rdata word0=0xAAAA0000:
- RDMEM shows mem_read=1, mem_addr=0x4.
- then a CMPTAG hit with proc_rdata=0xAAAA0000 and proc_stall=0.
REQ-021 Write 0x12345678 to 0x10 after it is cached -> no stall; a subsequent read of 0x10 returns 0x12345678 with mem_read=0.
REQ-022 Fill way0 and way1 of set 0 (tags A, B), read A, then miss on tag C -> way1 (B) is evicted; A still hits with no memory traffic.
REQ-023 Dirty eviction: dirty line at 0x10, then read miss on 0x50 (same set, both ways full, victim = the dirty way):
- WRTMEM shows mem_write=1, mem_addr=0x4 and the written data.
- then RDMEM shows mem_addr=0x14; the victim returns clean.
REQ-024 proc_read=proc_write=1 -> proc_stall=0, no memory request, cache contents unchanged.
REQ-025 Assert proc_reset_n=0 mid-RDMEM with no clock edge -> mem_read drops to 0 immediately; after release, the previously valid address misses.
